// File: rtl/rpn_evaluator_pkg.sv
// rpn_evaluator_pkg
//   Shared definitions for the RPN evaluator: token codes (same values the
//   infix->RPN converter emits), error-code encodings and a token classifier.
//   No ports; imported by the interface, the stack and the evaluator top.
package rpn_evaluator_pkg;

  localparam int TOK_W = 4;

  localparam logic [TOK_W-1:0] TOK_DIGIT_MAX = 4'h9;
  localparam logic [TOK_W-1:0] TOK_ADD       = 4'hA;
  localparam logic [TOK_W-1:0] TOK_SUB       = 4'hB;
  localparam logic [TOK_W-1:0] TOK_MUL       = 4'hC;
  localparam logic [TOK_W-1:0] TOK_EQ        = 4'hD;

  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

  typedef enum logic [1:0] {
    TK_DIGIT,
    TK_OP,
    TK_EQ,
    TK_BAD
  } tok_class_t;

  function automatic tok_class_t tok_class(input logic [TOK_W-1:0] tok);
    tok_class_t cls;
    if (tok <= TOK_DIGIT_MAX)                    cls = TK_DIGIT;
    else if (tok == TOK_EQ)                      cls = TK_EQ;
    else if (tok inside {TOK_ADD, TOK_SUB, TOK_MUL}) cls = TK_OP;
    else                                         cls = TK_BAD;
    return cls;
  endfunction

endpackage

// File: rtl/rpn_evaluator_if.sv
// rpn_evaluator_if
//   Token stream between the converter's output FIFO (master) and the
//   evaluator (slave). First-word-fall-through: data is valid while ready
//   is high; rd is the one-cycle acknowledge that pops the FIFO.
//   ready  master->slave  FIFO non-empty
//   data   master->slave  RPN token
//   rd     slave->master  token ack
interface rpn_evaluator_if;
  import rpn_evaluator_pkg::*;

  logic             ready;
  logic [TOK_W-1:0] data;
  logic             rd;

  modport master (output ready, output data, input rd);
  modport slave  (input ready, input data, output rd);

endinterface

// File: rtl/rpn_evaluator_stack.sv
// rpn_evaluator_stack
//   Value stack for the evaluator: DEPTH x WIDTH register array plus stack
//   pointer. The array itself is not reset; only sp is.
//   i_clk, i_rst        clock, async active-high reset of sp
//   i_push/i_push_data  write at sp, sp+1 (ignored when full)
//   i_pop_replace/data  write at sp-2, sp-1 (binary op: two pops + one push)
//   i_clear             sp <= 0
//   o_top/o_next        stk[sp-1] / stk[sp-2]
//   o_bottom            stk[0]
//   o_sp, o_full, o_empty  pointer and flags
module rpn_evaluator_stack
  import rpn_evaluator_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_data,
  input  logic                  i_pop_replace,
  input  logic [WIDTH-1:0]      i_replace_data,
  input  logic                  i_clear,
  output logic [WIDTH-1:0]      o_top,
  output logic [WIDTH-1:0]      o_next,
  output logic [WIDTH-1:0]      o_bottom,
  output logic [DEPTH_LOG2:0]   o_sp,
  output logic                  o_full,
  output logic                  o_empty
);

  // sp is one bit wider than the index so that sp==DEPTH (full) is representable
  logic [DEPTH_LOG2:0]   r_sp;
  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] w_idx_push;
  logic [DEPTH_LOG2-1:0] w_idx_top;
  logic [DEPTH_LOG2-1:0] w_idx_next;
  logic                  w_full;
  logic                  w_can_pop2;
  logic                  w_do_push;
  logic                  w_do_replace;

  assign w_idx_push   = r_sp[DEPTH_LOG2-1:0];
  assign w_idx_top    = w_idx_push - DEPTH_LOG2'(1);
  assign w_idx_next   = w_idx_push - DEPTH_LOG2'(2);
  assign w_full       = (r_sp == (DEPTH_LOG2+1)'(DEPTH));
  assign w_can_pop2   = (r_sp >= (DEPTH_LOG2+1)'(2));
  assign w_do_push    = i_push && !w_full;
  assign w_do_replace = i_pop_replace && w_can_pop2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sp <= '0;
    end else if (i_clear) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + 1'b1;
    end else if (w_do_replace) begin
      r_sp <= r_sp - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[w_idx_push] <= i_push_data;
    end else if (w_do_replace) begin
      r_mem[w_idx_next] <= i_replace_data;
    end
  end

  assign o_top    = r_mem[w_idx_top];
  assign o_next   = r_mem[w_idx_next];
  assign o_bottom = r_mem[0];
  assign o_sp     = r_sp;
  assign o_full   = w_full;
  assign o_empty  = (r_sp == '0);

endmodule

// File: rtl/rpn_evaluator.sv
// rpn_evaluator
//   Pops RPN tokens from the converter's FIFO, evaluates them on a value
//   stack and emits one result per '=' token. Arithmetic is modulo 2^WIDTH.
//   i_clk, i_rst     clock, async active-high reset
//   tok_if (slave)   token stream: ready/data in, rd (registered ack) out
//   o_result         last evaluated value, held
//   o_result_vld     1-cycle pulse when o_result updates
//   o_err            1-cycle pulse on an evaluation error
//   o_err_code       1 underflow, 2 overflow, 3 illegal token; held
//   o_busy           high whenever the FSM is not idle
//
//   state    | meaning
//   S_IDLE   | wait for a token, ack it and latch it
//   S_DECODE | classify token, check stack depth, or discard while draining
//   S_PUSH   | push zero-extended digit
//   S_POPB   | read right operand (top)
//   S_POPA   | read left operand (top-1)
//   S_CALC   | write a op b over the left operand, sp-1
//   S_EQ     | publish stk[0], empty the stack
//   S_ERR    | report error, empty the stack, start draining
module rpn_evaluator
  import rpn_evaluator_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  rpn_evaluator_if.slave   tok_if,
  output logic [WIDTH-1:0] o_result,
  output logic             o_result_vld,
  output logic             o_err,
  output logic [1:0]       o_err_code,
  output logic             o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_PUSH,
    S_POPB,
    S_POPA,
    S_CALC,
    S_EQ,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_in_rd;
  logic [TOK_W-1:0]   r_tok;
  logic               r_drain;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic               r_result_vld;
  logic               r_err;
  logic [1:0]         r_err_code;

  logic               w_fetch;
  logic               w_push;
  logic               w_pop_replace;
  logic               w_clear;
  logic               w_lat_a;
  logic               w_lat_b;
  logic               w_res_set;
  logic               w_err_set;
  logic               w_drain_set;
  logic               w_drain_clr;
  logic [1:0]         w_err_code_nxt;

  logic [WIDTH-1:0]   w_top;
  logic [WIDTH-1:0]   w_next;
  logic [WIDTH-1:0]   w_bottom;
  logic [WIDTH-1:0]   w_push_data;
  logic [WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]   w_alu;
  logic [DEPTH_LOG2:0] w_sp;
  logic               w_full;
  logic               w_empty;
  tok_class_t         w_cls;

  assign w_cls       = tok_class(r_tok);
  assign w_push_data = {{(WIDTH-TOK_W){1'b0}}, r_tok};

  rpn_evaluator_stack #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_stack (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_push         (w_push),
    .i_push_data    (w_push_data),
    .i_pop_replace  (w_pop_replace),
    .i_replace_data (w_alu),
    .i_clear        (w_clear),
    .o_top          (w_top),
    .o_next         (w_next),
    .o_bottom       (w_bottom),
    .o_sp           (w_sp),
    .o_full         (w_full),
    .o_empty        (w_empty)
  );

  // Product is evaluated at WIDTH bits, so the upper half is simply dropped
  assign w_prod = r_a * r_b;

  always_comb begin
    w_alu = r_a + r_b;
    case (r_tok)
      TOK_SUB: w_alu = r_a - r_b;
      TOK_MUL: w_alu = w_prod;
      default: w_alu = r_a + r_b;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch        = 1'b0;
    w_push         = 1'b0;
    w_pop_replace  = 1'b0;
    w_clear        = 1'b0;
    w_lat_a        = 1'b0;
    w_lat_b        = 1'b0;
    w_res_set      = 1'b0;
    w_err_set      = 1'b0;
    w_drain_set    = 1'b0;
    w_drain_clr    = 1'b0;
    w_err_code_nxt = ERR_UNDERFLOW;
    case (r_state)
      S_IDLE: begin
        if (tok_if.ready && !r_in_rd) begin
          w_fetch     = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (r_drain) begin
          // After an error everything up to and including '=' is swallowed
          w_drain_clr = (r_tok == TOK_EQ);
          w_state_nxt = S_IDLE;
        end else begin
          case (w_cls)
            TK_DIGIT: w_state_nxt = w_full ? S_ERR : S_PUSH;
            TK_OP:    w_state_nxt = (w_empty || w_sp == (DEPTH_LOG2+1)'(1)) ? S_ERR : S_POPB;
            TK_EQ:    w_state_nxt = (w_sp == (DEPTH_LOG2+1)'(1)) ? S_EQ : S_ERR;
            default:  w_state_nxt = S_ERR;
          endcase
        end
      end
      S_PUSH: begin
        w_push      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_POPB: begin
        w_lat_b     = 1'b1;
        w_state_nxt = S_POPA;
      end
      S_POPA: begin
        w_lat_a     = 1'b1;
        w_state_nxt = S_CALC;
      end
      S_CALC: begin
        w_pop_replace = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      S_EQ: begin
        w_res_set   = 1'b1;
        w_clear     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        // The error cause is recoverable from the token class alone
        w_err_set   = 1'b1;
        w_clear     = 1'b1;
        w_drain_set = 1'b1;
        case (w_cls)
          TK_DIGIT: w_err_code_nxt = ERR_OVERFLOW;
          TK_BAD:   w_err_code_nxt = ERR_ILLEGAL;
          default:  w_err_code_nxt = ERR_UNDERFLOW;
        endcase
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in_rd      <= 1'b0;
      r_tok        <= '0;
      r_drain      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_result_vld <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= '0;
    end else begin
      r_in_rd      <= w_fetch;
      r_result_vld <= w_res_set;
      r_err        <= w_err_set;
      if (w_fetch)     r_tok      <= tok_if.data;
      if (w_lat_b)     r_b        <= w_top;
      if (w_lat_a)     r_a        <= w_next;
      if (w_res_set)   r_result   <= w_bottom;
      if (w_err_set)   r_err_code <= w_err_code_nxt;
      if (w_drain_set)      r_drain <= 1'b1;
      else if (w_drain_clr) r_drain <= 1'b0;
    end
  end

  assign tok_if.rd    = r_in_rd;
  assign o_result     = r_result;
  assign o_result_vld = r_result_vld;
  assign o_err        = r_err;
  assign o_err_code   = r_err_code;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_rpn_evaluator.sv
module tb_rpn_evaluator;

  typedef struct packed {
    logic        is_err;
    logic [15:0] val;
  } ev_t;

  typedef struct {
    logic [127:0] toks;   // first token in the most significant used nibble
    int           ntok;
    int           nev;
    ev_t          e0;
    ev_t          e1;
  } vec_t;

  localparam int NV = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] result;
  logic        result_vld;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  rpn_evaluator_if tok_if ();

  rpn_evaluator #(
    .WIDTH      (16),
    .DEPTH      (16),
    .DEPTH_LOG2 (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .tok_if       (tok_if),
    .o_result     (result),
    .o_result_vld (result_vld),
    .o_err        (err),
    .o_err_code   (err_code),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  fifo_q[$];
  bit          stall_en = 1'b0;
  bit          prev_rd  = 1'b0;
  ev_t         got_q[$];
  int          ack_cyc[$];
  int          res_cyc[$];

  // reference model state
  logic [15:0] m_stk[$];
  bit          m_drain = 1'b0;
  ev_t         exp_q[$];

  vec_t        vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t ev_res(input logic [15:0] v);
    return {1'b0, v};
  endfunction

  function automatic ev_t ev_err(input logic [1:0] c);
    return {1'b1, 14'd0, c};
  endfunction

  // FIFO model, protocol checks and output monitor, all on the falling edge
  initial begin
    tok_if.ready = 1'b0;
    tok_if.data  = 4'h0;
    forever begin
      @(negedge clk);
      if (tok_if.rd) begin
        check("rd_only_when_ready", {31'd0, tok_if.ready}, 32'd1);
        check("rd_not_back_to_back", {31'd0, prev_rd}, 32'd0);
        ack_cyc.push_back(cyc);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      if (result_vld) begin
        got_q.push_back(ev_res(result));
        res_cyc.push_back(cyc);
      end
      if (err) got_q.push_back(ev_err(err_code));
      prev_rd = tok_if.rd;
      if (fifo_q.size() > 0 && !(stall_en && $urandom_range(0, 3) == 0)) begin
        tok_if.ready = 1'b1;
        tok_if.data  = fifo_q[0];
      end else begin
        tok_if.ready = 1'b0;
      end
    end
  end

  function automatic void model_err(input logic [1:0] code);
    exp_q.push_back(ev_err(code));
    m_stk.delete();
    m_drain = 1'b1;
  endfunction

  function automatic void model_tok(input logic [3:0] t);
    logic [15:0] a, b, r;
    if (m_drain) begin
      if (t == 4'hD) m_drain = 1'b0;
      return;
    end
    if (t <= 4'd9) begin
      if (m_stk.size() == 16) model_err(2'd2);
      else m_stk.push_back({12'd0, t});
    end else if (t == 4'hA || t == 4'hB || t == 4'hC) begin
      if (m_stk.size() < 2) model_err(2'd1);
      else begin
        b = m_stk.pop_back();
        a = m_stk.pop_back();
        if (t == 4'hA)      r = a + b;
        else if (t == 4'hB) r = a - b;
        else                r = a * b;
        m_stk.push_back(r);
      end
    end else if (t == 4'hD) begin
      if (m_stk.size() == 1) begin
        exp_q.push_back(ev_res(m_stk[0]));
        m_stk.delete();
      end else model_err(2'd1);
    end else begin
      model_err(2'd3);
    end
  endfunction

  function automatic logic [3:0] rand_tok();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55)      return 4'($urandom_range(0, 9));
    else if (r < 80) return 4'($urandom_range(10, 12));
    else if (r < 95) return 4'hD;
    else             return 4'($urandom_range(14, 15));
  endfunction

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((fifo_q.size() != 0 || busy || tok_if.rd) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check({tag, " idle_within_budget"}, {31'd0, (k < 5000)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_events(input string tag);
    check({tag, " n_events"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s ev%0d kind", tag, i), {31'd0, got_q[i].is_err}, {31'd0, exp_q[i].is_err});
      check($sformatf("%s ev%0d value", tag, i), {16'd0, got_q[i].val}, {16'd0, exp_q[i].val});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish after %0d cycles", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ev_t last;
    int  nack;

    vecs[0]  = '{128'h34A2CD,                            6, 1, ev_res(16'd14),   ev_t'(0)};
    vecs[1]  = '{128'h25BD,                              4, 1, ev_res(16'hFFFD), ev_t'(0)};
    vecs[2]  = '{128'h99C9C9C9CD,                       10, 1, ev_res(16'hE6A9), ev_t'(0)};
    vecs[3]  = '{128'hAD7D,                              4, 2, ev_err(2'd1),     ev_res(16'd7)};
    vecs[4]  = '{128'h12345678912345678D,               18, 1, ev_err(2'd2),     ev_t'(0)};
    vecs[5]  = '{128'h1ED12DD,                           7, 2, ev_err(2'd3),     ev_err(2'd1)};
    vecs[6]  = '{128'h01BD,                              4, 1, ev_res(16'hFFFF), ev_t'(0)};
    vecs[7]  = '{128'h1111111111111111AAAAAAAAAAAAAAAD, 32, 1, ev_res(16'd16),   ev_t'(0)};
    vecs[8]  = '{128'hDD,                                2, 1, ev_err(2'd1),     ev_t'(0)};
    vecs[9]  = '{128'hF5D,                               3, 1, ev_err(2'd3),     ev_t'(0)};
    vecs[10] = '{128'h2A3D,                              4, 1, ev_err(2'd1),     ev_t'(0)};
    vecs[11] = '{128'h87B4CD,                            6, 1, ev_res(16'd4),    ev_t'(0)};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset result",     {16'd0, result},     32'd0);
    check("reset result_vld", {31'd0, result_vld}, 32'd0);
    check("reset err",        {31'd0, err},        32'd0);
    check("reset err_code",   {30'd0, err_code},   32'd0);
    check("reset busy",       {31'd0, busy},       32'd0);
    check("reset in_rd",      {31'd0, tok_if.rd},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed table
    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < vecs[v].ntok; i++)
        fifo_q.push_back(vecs[v].toks[4*(vecs[v].ntok-1-i) +: 4]);
      wait_idle($sformatf("vec%0d", v));
      check($sformatf("vec%0d n_events", v), got_q.size(), vecs[v].nev);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d ev0", v), {15'd0, got_q[0]}, {15'd0, vecs[v].e0});
      end
      if (got_q.size() > 1) begin
        check($sformatf("vec%0d ev1", v), {15'd0, got_q[1]}, {15'd0, vecs[v].e1});
      end
      last = (vecs[v].nev == 2) ? vecs[v].e1 : vecs[v].e0;
      if (last.is_err) check($sformatf("vec%0d err_code held", v), {30'd0, err_code}, {30'd0, last.val[1:0]});
      else             check($sformatf("vec%0d result held", v), {16'd0, result}, {16'd0, last.val});
      got_q.delete();
    end

    // token pacing and result latency
    ack_cyc.delete();
    res_cyc.delete();
    fifo_q.push_back(4'h1);
    fifo_q.push_back(4'h2);
    fifo_q.push_back(4'hA);
    fifo_q.push_back(4'hD);
    wait_idle("latency");
    check("latency ack count", ack_cyc.size(), 32'd4);
    if (ack_cyc.size() == 4) begin
      check("digit pacing 1", ack_cyc[1] - ack_cyc[0], 32'd3);
      check("digit pacing 2", ack_cyc[2] - ack_cyc[1], 32'd3);
      check("operator pacing", ack_cyc[3] - ack_cyc[2], 32'd5);
    end
    check("latency result count", res_cyc.size(), 32'd1);
    if (res_cyc.size() == 1 && ack_cyc.size() == 4)
      check("eq ack to result_vld", res_cyc[0] - ack_cyc[3], 32'd2);
    check("latency result value", {16'd0, result}, 32'd3);
    got_q.delete();

    // nothing happens while the FIFO is empty
    nack = ack_cyc.size();
    repeat (40) @(negedge clk);
    check("no ack while empty", ack_cyc.size(), nack);
    check("idle not busy", {31'd0, busy}, 32'd0);

    // reset in the middle of an expression
    fifo_q.push_back(4'h5);
    fifo_q.push_back(4'h6);
    wait_idle("pre_reset");
    got_q.delete();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("busy during reset", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("no pulses around reset", got_q.size(), 32'd0);
    check("result cleared by reset", {16'd0, result}, 32'd0);
    fifo_q.push_back(4'h9);
    fifo_q.push_back(4'hD);
    wait_idle("post_reset");
    check("post reset n_events", got_q.size(), 32'd1);
    if (got_q.size() == 1) check("post reset result", {15'd0, got_q[0]}, {15'd0, ev_res(16'd9)});
    got_q.delete();

    // randomized streams with FIFO stalls against the reference model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_stk.delete();
    m_drain = 1'b0;
    got_q.delete();
    exp_q.delete();
    stall_en = 1'b1;
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < 20; i++) begin
        logic [3:0] t;
        t = rand_tok();
        fifo_q.push_back(t);
        model_tok(t);
      end
      wait_idle($sformatf("rand%0d", b));
      compare_events($sformatf("rand%0d", b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
